// File: rtl/bp_meta_pipe.sv
// Branch-prediction metadata pipeline: carries {bht_hit, bht_ctr} from lookup to EX and
// computes the BHT write-back counter and mispredict flag. Optional statistics under BP_META_STATS_EN.
module bp_meta_pipe #(
    parameter int STAGES = 2,
    parameter int CTR_W  = 2,
    parameter int STAT_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [STAGES-1:0] bubble,
    input  logic [STAGES-1:0] flush,
    input  logic              bht_hit,
    input  logic [CTR_W-1:0]  bht_ctr,
    input  logic              br_valid_ex,
    input  logic              br_taken_ex,
    input  logic              stat_clr,
    output logic              bht_hit_ex,
    output logic [CTR_W-1:0]  bht_ctr_ex,
    output logic              pred_taken_ex,
    output logic [CTR_W-1:0]  ctr_next_ex,
    output logic              mispredict_ex,
    output logic [STAT_W-1:0] br_cnt,
    output logic [STAT_W-1:0] miss_cnt
);

    localparam logic [CTR_W-1:0] CTR_MAX = '1;
    localparam logic [CTR_W-1:0] CTR_ONE = {{(CTR_W-1){1'b0}}, 1'b1};
    localparam logic [CTR_W-1:0] WEAK_T  = {1'b1, {(CTR_W-1){1'b0}}};
    localparam logic [CTR_W-1:0] WEAK_NT = ~WEAK_T;

    logic [STAGES-1:0]            r_hit;
    logic [STAGES-1:0][CTR_W-1:0] r_ctr;
    logic [STAGES-1:0]            w_src_hit;
    logic [STAGES-1:0][CTR_W-1:0] w_src_ctr;

    assign w_src_hit[0] = bht_hit;
    assign w_src_ctr[0] = bht_ctr;

    for (genvar g = 1; g < STAGES; g++) begin : g_src
        assign w_src_hit[g] = r_hit[g-1];
        assign w_src_ctr[g] = r_ctr[g-1];
    end

    // Each stage is independent: bubble holds (and beats flush), flush zeroes.
    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_hit[g] <= 1'b0;
                r_ctr[g] <= '0;
            end else if (!bubble[g]) begin
                if (flush[g]) begin
                    r_hit[g] <= 1'b0;
                    r_ctr[g] <= '0;
                end else begin
                    r_hit[g] <= w_src_hit[g];
                    r_ctr[g] <= w_src_ctr[g];
                end
            end
        end
    end

    assign bht_hit_ex    = r_hit[STAGES-1];
    assign bht_ctr_ex    = r_ctr[STAGES-1];
    assign pred_taken_ex = bht_hit_ex & bht_ctr_ex[CTR_W-1];
    assign mispredict_ex = br_valid_ex & (pred_taken_ex != br_taken_ex);

    // A BHT miss restarts the counter at the weak state matching the outcome.
    always_comb begin
        ctr_next_ex = bht_ctr_ex;
        if (bht_hit_ex) begin
            if (br_taken_ex) begin
                if (bht_ctr_ex != CTR_MAX) ctr_next_ex = bht_ctr_ex + CTR_ONE;
            end else begin
                if (bht_ctr_ex != '0) ctr_next_ex = bht_ctr_ex - CTR_ONE;
            end
        end else begin
            ctr_next_ex = br_taken_ex ? WEAK_T : WEAK_NT;
        end
    end

`ifdef BP_META_STATS_EN
    localparam logic [STAT_W-1:0] STAT_ONE = {{(STAT_W-1){1'b0}}, 1'b1};

    logic              w_ex_release;
    logic [STAT_W-1:0] r_br_cnt;
    logic [STAT_W-1:0] r_miss_cnt;

    // Count on release only, so a branch stalled in EX is counted once.
    assign w_ex_release = ~bubble[STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_br_cnt   <= '0;
            r_miss_cnt <= '0;
        end else if (stat_clr) begin
            r_br_cnt   <= '0;
            r_miss_cnt <= '0;
        end else begin
            if (br_valid_ex & w_ex_release)   r_br_cnt   <= r_br_cnt + STAT_ONE;
            if (mispredict_ex & w_ex_release) r_miss_cnt <= r_miss_cnt + STAT_ONE;
        end
    end

    assign br_cnt   = r_br_cnt;
    assign miss_cnt = r_miss_cnt;
`else
    logic w_stat_clr_unused;

    assign w_stat_clr_unused = stat_clr;
    assign br_cnt            = '0;
    assign miss_cnt          = '0;
`endif

endmodule

// File: tb/tb_bp_meta_pipe.sv
// Scoreboard bench for bp_meta_pipe (STAGES=2, CTR_W=2, STAT_W=4) plus a CTR_W=3 instance.
module tb_bp_meta_pipe;

`ifdef BP_META_STATS_EN
  localparam bit STATS_ON = 1'b1;
`else
  localparam bit STATS_ON = 1'b0;
`endif

  // Vector layout: [17:15] w3 ctr_next, [14] hit, [13:12] ctr, [11] pred, [10:9] next, [8] mis, [7:4] br, [3:0] miss
  localparam logic [17:0] M_MAIN = 18'h07FFF;
  localparam logic [17:0] M_ALL  = 18'h3FFFF;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] bubble = '0;
  logic [1:0] flush = '0;
  logic       bht_hit = 1'b0;
  logic [1:0] bht_ctr = '0;
  logic       br_valid_ex = 1'b0;
  logic       br_taken_ex = 1'b0;
  logic       stat_clr = 1'b0;
  logic       bht_hit_ex, pred_taken_ex, mispredict_ex;
  logic [1:0] bht_ctr_ex, ctr_next_ex;
  logic [3:0] br_cnt, miss_cnt;

  logic       w3_hit = 1'b0;
  logic [2:0] w3_ctr = '0;
  logic       w3_taken = 1'b1;
  logic       w3_zero = 1'b0;
  logic [2:0] w3_next;
  logic       w3_unused_hit, w3_unused_pred, w3_unused_mis;
  logic [2:0] w3_unused_ctr;
  logic [3:0] w3_unused_br, w3_unused_miss;

  logic [17:0] exp_q[$];
  logic [17:0] msk_q[$];
  string       name_q[$];
  int          checks = 0;
  int          failures = 0;
  event        chk_ev;

  bp_meta_pipe #(.STAGES(2), .CTR_W(2), .STAT_W(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .bubble(bubble), .flush(flush),
    .bht_hit(bht_hit), .bht_ctr(bht_ctr), .br_valid_ex(br_valid_ex),
    .br_taken_ex(br_taken_ex), .stat_clr(stat_clr), .bht_hit_ex(bht_hit_ex),
    .bht_ctr_ex(bht_ctr_ex), .pred_taken_ex(pred_taken_ex), .ctr_next_ex(ctr_next_ex),
    .mispredict_ex(mispredict_ex), .br_cnt(br_cnt), .miss_cnt(miss_cnt)
  );

  bp_meta_pipe #(.STAGES(1), .CTR_W(3), .STAT_W(4)) u_w3 (
    .clk(clk), .rst_n(rst_n), .bubble(w3_zero), .flush(w3_zero),
    .bht_hit(w3_hit), .bht_ctr(w3_ctr), .br_valid_ex(w3_zero),
    .br_taken_ex(w3_taken), .stat_clr(w3_zero), .bht_hit_ex(w3_unused_hit),
    .bht_ctr_ex(w3_unused_ctr), .pred_taken_ex(w3_unused_pred), .ctr_next_ex(w3_next),
    .mispredict_ex(w3_unused_mis), .br_cnt(w3_unused_br), .miss_cnt(w3_unused_miss)
  );

  // clock / reset
  always #5 clk = ~clk;

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic [1:0] bub, input logic [1:0] fl, input logic hit,
                     input logic [1:0] ctr, input logic vld, input logic tkn, input logic clr);
    bubble = bub; flush = fl; bht_hit = hit; bht_ctr = ctr;
    br_valid_ex = vld; br_taken_ex = tkn; stat_clr = clr;
  endtask

  function automatic logic [7:0] st(input int b, input int m);
    logic [3:0] b4, m4;
    b4 = b[3:0];
    m4 = m[3:0];
    return STATS_ON ? {b4, m4} : 8'h00;
  endfunction

  task automatic push(input string nm, input logic hit, input logic [1:0] ctr, input logic pred,
                      input logic [1:0] nxt, input logic mis, input logic [7:0] s,
                      input logic [2:0] w3, input logic [17:0] msk);
    exp_q.push_back({w3, hit, ctr, pred, nxt, mis, s});
    msk_q.push_back(msk);
    name_q.push_back(nm);
  endtask

  // scoreboard monitor
  initial begin
    logic [17:0] act, e, m;
    string nm;
    forever begin
      @(negedge clk or chk_ev);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        m = msk_q.pop_front();
        nm = name_q.pop_front();
        act = {w3_next, bht_hit_ex, bht_ctr_ex, pred_taken_ex, ctr_next_ex, mispredict_ex,
               br_cnt, miss_cnt};
        checks++;
        if ((act & m) !== (e & m)) begin
          failures++;
          $display("FAIL %s: got %h expected %h (mask %h)", nm, act & m, e & m, m);
        end
      end
    end
  end

  initial begin
    // reset state with comb EX outputs
    drv(2'b00, 2'b00, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0);
    step();
    push("rst_taken", 0, 2'd0, 0, 2'd2, 1, st(0, 0), 3'd0, M_MAIN);
    step();
    br_taken_ex = 1'b0;
    push("rst_not_taken", 0, 2'd0, 0, 2'd1, 0, st(0, 0), 3'd0, M_MAIN);

    // flow and latency
    step(); rst_n = 1'b1;
    drv(2'b00, 2'b00, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
    w3_hit = 1'b1; w3_ctr = 3'd3;
    push("lat_edge0", 0, 2'd0, 0, 2'd1, 0, st(0, 0), 3'd0, M_MAIN);
    step();
    drv(2'b00, 2'b00, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0);
    w3_ctr = 3'd7;
    push("lat_edge1", 0, 2'd0, 0, 2'd1, 0, st(0, 0), 3'd4, M_ALL);
    step();
    drv(2'b00, 2'b00, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    w3_hit = 1'b0; w3_ctr = 3'd5;
    push("flow_mispredict", 1, 2'd2, 1, 2'd1, 1, st(0, 0), 3'd7, M_ALL);

    // bubble beats flush, then flush
    step();
    drv(2'b10, 2'b10, 1'b1, 2'd1, 1'b1, 1'b1, 1'b0);
    push("sat_inc_max", 1, 2'd3, 1, 2'd3, 0, st(1, 1), 3'd4, M_ALL);
    step();
    drv(2'b00, 2'b10, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    push("bubble_over_flush", 1, 2'd3, 1, 2'd2, 0, st(1, 1), 3'd0, M_MAIN);
    step();
    drv(2'b00, 2'b00, 1'b1, 2'd0, 1'b1, 1'b0, 1'b0);
    push("flush_zero", 0, 2'd0, 0, 2'd1, 0, st(1, 1), 3'd0, M_MAIN);

    // counter update cases
    step();
    drv(2'b00, 2'b00, 1'b0, 2'd3, 1'b1, 1'b1, 1'b0);
    push("miss_taken", 0, 2'd0, 0, 2'd2, 1, st(2, 1), 3'd0, M_MAIN);
    step();
    drv(2'b00, 2'b00, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0);
    push("sat_dec_floor", 1, 2'd0, 0, 2'd0, 0, st(3, 2), 3'd0, M_MAIN);
    step();
    drv(2'b00, 2'b00, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    push("miss_ctr3_not_taken", 0, 2'd3, 0, 2'd1, 0, st(4, 2), 3'd0, M_MAIN);
    step();
    drv(2'b00, 2'b00, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    push("no_valid_no_mis", 1, 2'd2, 1, 2'd1, 0, st(5, 2), 3'd0, M_MAIN);

    // branch stalled three cycles in EX counts once on release
    for (int i = 0; i < 3; i++) begin
      step();
      drv(2'b10, 2'b00, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0);
      push("stall_hold", 0, 2'd0, 0, 2'd2, 1, st(5, 2), 3'd0, M_MAIN);
    end
    step();
    drv(2'b00, 2'b00, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0);
    push("stall_release", 0, 2'd0, 0, 2'd2, 1, st(5, 2), 3'd0, M_MAIN);
    step();
    drv(2'b00, 2'b00, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    push("stall_counted_once", 0, 2'd0, 0, 2'd1, 0, st(6, 3), 3'd0, M_MAIN);

    // clear beats same-cycle increment
    step();
    drv(2'b00, 2'b00, 1'b0, 2'd0, 1'b1, 1'b1, 1'b1);
    push("pre_clear", 0, 2'd0, 0, 2'd2, 1, st(6, 3), 3'd0, M_MAIN);
    step();
    drv(2'b00, 2'b00, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    push("clear_wins", 0, 2'd0, 0, 2'd1, 0, st(0, 0), 3'd0, M_MAIN);

    // 16 counted branches wrap a 4-bit counter
    for (int k = 0; k < 16; k++) begin
      step();
      drv(2'b00, 2'b00, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
      push("wrap_count", 0, 2'd0, 0, 2'd1, 0, st(k, 0), 3'd0, M_MAIN);
    end
    step();
    drv(2'b00, 2'b00, 1'b1, 2'd3, 1'b1, 1'b1, 1'b0);
    push("wrap_to_zero", 0, 2'd0, 0, 2'd2, 1, st(0, 0), 3'd0, M_MAIN);
    step();
    drv(2'b00, 2'b00, 1'b1, 2'd3, 1'b1, 1'b1, 1'b0);
    push("refill", 0, 2'd0, 0, 2'd2, 1, st(1, 1), 3'd0, M_MAIN);
    step();
    drv(2'b00, 2'b00, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    push("before_reset", 1, 2'd3, 1, 2'd2, 0, st(2, 2), 3'd0, M_MAIN);

    // asynchronous reset mid-cycle clears everything without a clock edge
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    push("async_reset", 0, 2'd0, 0, 2'd1, 0, st(0, 0), 3'd0, M_MAIN);
    ->chk_ev;
    #1;
    step();
    rst_n = 1'b1;

    repeat (3) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending entries expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
